// File: rtl/thr2pry_pipe.sv
// Two-stage valid/ready pipeline that turns a thermometer code into its lowest-edge
// one-hot vector and binary index, flags malformed codes and counts them saturatingly.
module thr2pry_pipe #(
  parameter  int WIDTH    = 8,
  localparam int WIDTHLOG = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_vld,
  output logic                s_rdy,
  input  logic [WIDTH-1:0]    s_thr,
  output logic                m_vld,
  input  logic                m_rdy,
  output logic [WIDTH-1:0]    m_pry,
  output logic [WIDTHLOG-1:0] m_enc,
  output logic                m_any,
  output logic                m_err,
  input  logic                err_clr,
  output logic [15:0]         err_cnt
);

  logic                vld1;
  logic [WIDTH-1:0]    thr1;
  logic                rdy2;

  logic [WIDTH-1:0]    edg;
  logic [WIDTH-1:0]    dec_pry;
  logic [WIDTHLOG-1:0] dec_enc;
  logic                dec_any;
  logic                dec_err;

  assign rdy2  = ~m_vld | rdy2_term();
  assign s_rdy = ~vld1 | rdy2;

  function automatic logic rdy2_term();
    return m_rdy;
  endfunction

  // NOTE: every variable is given a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    edg     = thr1 & ~(thr1 << 1);
    dec_pry = '0;
    dec_enc = '0;
    // Descending scan: the last hit is the lowest edge, giving priority semantics on bubbles.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (edg[i]) begin
        dec_pry    = '0;
        dec_pry[i] = 1'b1;
        dec_enc    = WIDTHLOG'(i);
      end
    end
    dec_any = |thr1;
    dec_err = dec_any & (thr1 != ~(dec_pry - WIDTH'(1)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1 <= 1'b0;
      thr1 <= '0;
    end else if (s_rdy) begin
      vld1 <= s_vld;
      if (s_vld) thr1 <= s_thr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 1'b0;
      m_pry <= '0;
      m_enc <= '0;
      m_any <= 1'b0;
      m_err <= 1'b0;
    end else if (rdy2) begin
      m_vld <= vld1;
      if (vld1) begin
        m_pry <= dec_pry;
        m_enc <= dec_enc;
        m_any <= dec_any;
        m_err <= dec_err;
      end
    end
  end

  // Clear wins over a same-cycle erroneous transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (m_vld && m_rdy && m_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_thr2pry_pipe.sv
// Self-checking bench for thr2pry_pipe: directed literal vectors plus a queue-based
// model checked on every falling edge.
module tb_thr2pry_pipe;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] pry;
    logic [2:0]   enc;
    logic         any;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_vld = 1'b0;
  logic         s_rdy;
  logic [W-1:0] s_thr = '0;
  logic         m_vld;
  logic         m_rdy = 1'b1;
  logic [W-1:0] m_pry;
  logic [2:0]   m_enc;
  logic         m_any;
  logic         m_err;
  logic         err_clr = 1'b0;
  logic [15:0]  err_cnt;

  logic         w1_s_vld = 1'b0;
  logic         w1_s_rdy;
  logic [0:0]   w1_s_thr = '0;
  logic         w1_m_vld;
  logic [0:0]   w1_m_pry;
  logic [0:0]   w1_m_enc;
  logic         w1_m_any;
  logic         w1_m_err;
  logic [15:0]  w1_err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  thr2pry_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy), .s_thr(s_thr),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_pry(m_pry), .m_enc(m_enc), .m_any(m_any),
    .m_err(m_err), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  thr2pry_pipe #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .s_vld(w1_s_vld), .s_rdy(w1_s_rdy), .s_thr(w1_s_thr),
    .m_vld(w1_m_vld), .m_rdy(1'b1), .m_pry(w1_m_pry), .m_enc(w1_m_enc), .m_any(w1_m_any),
    .m_err(w1_m_err), .err_clr(1'b0), .err_cnt(w1_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal code = ones from the lowest set bit all the way to the top.
  function automatic exp_t model(input logic [W-1:0] thr);
    exp_t         e;
    logic [W-1:0] ones;
    int           k;
    e = '0;
    k = -1;
    for (int i = 0; i < W; i++) if (thr[i] && k < 0) k = i;
    if (k >= 0) begin
      ones  = '1;
      e.pry = W'(1) << k;
      e.enc = 3'(k);
      e.any = 1'b1;
      e.err = (thr != (ones << k));
    end
    return e;
  endfunction

  exp_t        q[$];
  logic [15:0] mdl_cnt = '0;
  logic        stalled = 1'b0;
  exp_t        held;

  always @(negedge clk) begin
    exp_t f;
    exp_t cur;
    cur = '{pry: m_pry, enc: m_enc, any: m_any, err: m_err};
    if (rst) begin
      q.delete();
      mdl_cnt = '0;
      stalled = 1'b0;
      check("rst_m_vld", 32'(m_vld), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
    end else begin
      check("err_cnt", 32'(err_cnt), 32'(mdl_cnt));
      check("s_rdy", 32'(s_rdy), 32'((q.size() < 2) || m_rdy));
      if (stalled) check("stall_stable", 32'(cur), 32'(held));
      f = '0;
      if (m_vld) begin
        if (q.size() == 0) begin
          check("m_vld_with_empty_model", 32'(m_vld), 32'd0);
        end else begin
          f = q[0];
          check("m_out", 32'(cur), 32'(f));
          if (m_rdy) void'(q.pop_front());
        end
      end
      if (err_clr) mdl_cnt = '0;
      else if (m_vld && m_rdy && f.err && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
      if (s_vld && s_rdy) q.push_back(model(s_thr));
      held    = cur;
      stalled = m_vld && !m_rdy;
    end
  end

  // Single unstalled transfer through an empty pipeline, checked against literals.
  task automatic xfer(input logic [W-1:0] thr, input logic [W-1:0] pry, input int enc,
                      input logic any, input logic err, input string name);
    s_vld = 1'b1;
    s_thr = thr;
    @(posedge clk); #1;
    s_vld = 1'b0;
    @(posedge clk); #1;
    check({name, "_vld"}, 32'(m_vld), 32'd1);
    check({name, "_pry"}, 32'(m_pry), 32'(pry));
    check({name, "_enc"}, 32'(m_enc), 32'(enc));
    check({name, "_any"}, 32'(m_any), 32'(any));
    check({name, "_err"}, 32'(m_err), 32'(err));
  endtask

  logic [W-1:0] codes [8] = '{8'hF8, 8'hFF, 8'h80, 8'h00, 8'hC0, 8'hFE, 8'hE0, 8'hFC};

  initial begin
    exp_t e;
    #1;
    check("reset_m_vld", 32'(m_vld), 32'd0);
    check("reset_m_pry", 32'(m_pry), 32'd0);
    check("reset_m_enc", 32'(m_enc), 32'd0);
    check("reset_flags", 32'({m_any, m_err}), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);

    e = model(8'b1011_0000);
    check("model_bubble", 32'(e), 32'({8'b0001_0000, 3'd4, 1'b1, 1'b1}));
    e = model(8'b1111_1000);
    check("model_legal", 32'(e), 32'({8'b0000_1000, 3'd3, 1'b1, 1'b0}));

    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_rdy_after_reset", 32'(s_rdy), 32'd1);

    xfer(8'b1111_1000, 8'b0000_1000, 3, 1'b1, 1'b0, "f8");
    xfer(8'hFF, 8'h01, 0, 1'b1, 1'b0, "ff");
    xfer(8'h80, 8'h80, 7, 1'b1, 1'b0, "80");
    xfer(8'h00, 8'h00, 0, 1'b0, 1'b0, "00");
    check("err_cnt_after_zero", 32'(err_cnt), 32'd0);
    xfer(8'b1011_0000, 8'b0001_0000, 4, 1'b1, 1'b1, "bubble");
    @(posedge clk); #1;
    check("err_cnt_bubble", 32'(err_cnt), 32'd1);
    xfer(8'b0011_1000, 8'h08, 3, 1'b1, 1'b1, "nonreach");
    @(posedge clk); #1;
    check("err_cnt_nonreach", 32'(err_cnt), 32'd2);

    // Backpressure: eight legal codes with random m_rdy.
    begin
      int i = 0;
      int budget = 0;
      while (i < 8 && budget < 400) begin
        @(posedge clk); #1;
        m_rdy = 1'($urandom_range(0, 1));
        s_vld = 1'b1;
        s_thr = codes[i];
        @(negedge clk);
        if (s_rdy) i++;
        budget++;
      end
      check("bp_all_accepted", 32'(i), 32'd8);
      @(posedge clk); #1;
      s_vld = 1'b0;
      m_rdy = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("bp_drained", 32'(q.size()), 32'd0);
    end

    // Saturation.
    s_vld = 1'b1;
    s_thr = 8'hB0;
    repeat (65540) @(posedge clk);
    #1;
    s_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("err_cnt_saturated", 32'(err_cnt), 32'hFFFF);
    xfer(8'h30, 8'h10, 4, 1'b1, 1'b1, "sat_more");
    @(posedge clk); #1;
    check("err_cnt_holds", 32'(err_cnt), 32'hFFFF);

    // Clear against a simultaneous erroneous transfer.
    s_vld = 1'b1;
    s_thr = 8'hB0;
    repeat (2) @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    s_vld = 1'b0;
    check("err_clr_priority", 32'(err_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset with both stages full.
    m_rdy = 1'b0;
    s_vld = 1'b1;
    s_thr = 8'hF0;
    repeat (3) @(posedge clk);
    #1;
    check("full_s_rdy", 32'(s_rdy), 32'd0);
    s_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_m_vld", 32'(m_vld), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_rdy = 1'b1;
    @(posedge clk); #1;
    check("post_rst_empty", 32'(m_vld), 32'd0);
    xfer(8'hE0, 8'h20, 5, 1'b1, 1'b0, "post_rst");

    // WIDTH=1 instance.
    w1_s_vld = 1'b1;
    w1_s_thr = 1'b1;
    @(posedge clk); #1;
    w1_s_thr = 1'b0;
    @(posedge clk); #1;
    w1_s_vld = 1'b0;
    check("w1_one", 32'({w1_m_vld, w1_m_pry, w1_m_enc, w1_m_any, w1_m_err}), 32'b11010);
    @(posedge clk); #1;
    check("w1_zero", 32'({w1_m_vld, w1_m_pry, w1_m_enc, w1_m_any, w1_m_err}), 32'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thr2pry_pipe.md
# thr2pry_pipe

Pipelined thermometer-to-priority decoder, the inverse of the priority-to-thermometer conversion in the synthesis-primitives library. It accepts a thermometer code over a valid/ready stream and recovers the lowest-set-bit one-hot vector and its binary index. It also flags malformed (bubbled) codes and keeps a saturating error counter. It sits between a thermometer-coded source (e.g. a priority stage or comparator bank) and downstream arbitration logic that needs one-hot and index forms.

## Interface
- WIDTH, 8, thermometer/one-hot width (≥1)
- WIDTHLOG, $clog2(WIDTH) but at least 1, index width (localparam, not overridable)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- s_vld  input  1  input transfer valid
- s_rdy  output  1  input transfer ready
- s_thr  input  WIDTH  thermometer code; legal form is ones from bit k up to bit WIDTH-1, zeros below, or all zeros
- m_vld  output  1  output transfer valid
- m_rdy  input  1  output transfer ready
- m_pry  output  WIDTH  one-hot of lowest rising edge; 0 if none
- m_enc  output  WIDTHLOG  binary index of m_pry; 0 if m_any=0
- m_any  output  1  m_pry non-zero
- m_err  output  1  input code was not a legal thermometer code
- err_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  16  saturating count of erroneous output transfers

## Operation
- Edge vector: edg = thr & ~(thr << 1), truncated to WIDTH bits.
- m_pry = lowest set bit of edg. This is priority semantics: on bubbles, the lowest edge wins.
- m_enc = index of the m_pry bit.
- m_any = |thr, which is equivalent to |edg.
- m_err = m_any & (thr != ~(m_pry - 1)), evaluated over WIDTH bits.
  - Catches codes with multiple edges.
  - Catches codes whose ones do not reach bit WIDTH-1.
  - All-zero input is legal: m_err=0.
- Two register stages.
  - Stage 1 captures s_thr on an accepted input transfer (s_vld & s_rdy).
  - Stage 2 captures the decoded outputs (m_pry, m_enc, m_any, m_err) from stage 1.
  - Each stage has its own valid bit; m_vld is the stage-2 valid bit.
- Backpressure:
  - rdy2 = ~m_vld | m_rdy
  - s_rdy = ~vld1 | rdy2
  - Both are combinational from m_rdy.
  - A stage loads when its upstream valid is high and its own ready is high.
  - A stage holds data and valid unchanged while stalled.
  - A stage clears its valid when it is drained and receives no new load.
- Output data stays stable while m_vld=1 and m_rdy=0.
- err_cnt increments by 1 on each output transfer (m_vld & m_rdy) with m_err=1.
  - Saturates at 16'hFFFF.
  - err_clr=1 forces 0 on the next edge and takes priority over a simultaneous increment.

## Timing
- Reset (asynchronous assert, de-assert synchronous to clk by the environment):
  - vld1=0, m_vld=0, stage data=0.
  - m_pry=0, m_enc=0, m_any=0, m_err=0, err_cnt=0.
  - s_rdy=1 from the first cycle after reset.
- Latency: an input accepted at edge N is presented on m_vld/m_* after edge N+1 (visible in cycle N+1 to N+2) when unstalled. That is 2 register stages, with data appearing 1 cycle after stage-1 capture.
- Throughput: one transfer per cycle with m_rdy held at 1.
- Full pipeline (both stages valid) with m_rdy=0 gives s_rdy=0.
- When m_rdy rises, s_rdy rises in the same cycle and both stages advance on the next edge.
- Reset asserted mid-operation discards all in-flight data immediately. No output transfer occurs for it and err_cnt is not updated.
- WIDTH=1:
  - m_enc is always 0.
  - thr=1 gives pry=1, err=0.
  - thr=0 gives any=0.

## Test plan
- WIDTH=8, m_rdy=1, s_thr=8'b1111_1000 → after 2 edges m_pry=8'b0000_1000, m_enc=3, m_any=1, m_err=0. Then s_thr=8'hFF → m_pry=8'h01, m_enc=0. Then s_thr=8'h80 → m_pry=8'h80, m_enc=7.
- s_thr=8'h00 → m_pry=0, m_enc=0, m_any=0, m_err=0, err_cnt unchanged.
- Bubble s_thr=8'b1011_0000 → m_pry=8'b0001_0000, m_enc=4, m_err=1, err_cnt+1. Non-reaching s_thr=8'b0011_1000 → m_pry=8'h08, m_enc=3, m_err=1.
- Backpressure:
  - Stream 8 legal codes back-to-back with m_rdy toggling pseudo-randomly.
  - Require s_rdy=0 whenever both stages are full and m_rdy=0.
  - Require outputs stable while stalled, no loss or duplication, and order preserved against a scoreboard built from the priority-to-thermometer model.
- Counter:
  - Preload by driving 65 540 erroneous transfers → err_cnt=16'hFFFF and holds.
  - err_clr together with an erroneous transfer → err_cnt=0.
- Reset mid-stream: assert rst with both stages valid → m_vld=0 and err_cnt=0 asynchronously. After release, the first new input appears after 2 edges with no stale data.
